// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions used by the fetch path.
// Fetch entries are stored as {pc, instr}, with pc in the upper half.
package rv32im_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_queue_if.sv
// Push (fetch side) and pop (decode side) handshake bundle for the fetch queue.
// The queue uses the slave modport; fetch and decode logic use the master modport.
interface if_fetch_queue_if #(
    parameter int XLEN = rv32im_pkg::XLEN
);
    logic            push_valid;
    logic            push_ready;
    logic [XLEN-1:0] push_pc;
    logic [XLEN-1:0] push_instr;
    logic            pop_valid;
    logic            pop_ready;
    logic [XLEN-1:0] pop_pc;
    logic [XLEN-1:0] pop_instr;

    modport master (
        output push_valid, push_pc, push_instr, pop_ready,
        input  push_ready, pop_valid, pop_pc, pop_instr
    );

    modport slave (
        input  push_valid, push_pc, push_instr, pop_ready,
        output push_ready, pop_valid, pop_pc, pop_instr
    );
endinterface

// File: rtl/if_fetch_queue_regfile.sv
// fq_regfile: DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are never reset; occupancy is tracked
// by the pointers in the parent.
module fq_regfile #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction prefetch FIFO between fetch and IF/ID.
// Holds {pc, instr} pairs, delivers them in order, and drops everything on a
// redirect (flush). Pointers carry an extra wrap bit so full and empty are
// distinguishable with all DEPTH slots usable.
// Optional feature: define FQ_BYPASS_EN to let a push into an empty queue be
// presented on the pop side in the same cycle (not stored if consumed).
module if_fetch_queue
    import rv32im_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = rv32im_pkg::XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    if_fetch_queue_if.slave        fq,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              empty, full;
    logic              push_fire, pop_fire, store_push;
    logic [2*XLEN-1:0] rd_data;

    fq_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_regfile (
        .clk   (clk),
        .we    (store_push),
        .waddr (wr_ptr[IDX_W-1:0]),
        .wdata ({fq.push_pc, fq.push_instr}),
        .raddr (rd_ptr[IDX_W-1:0]),
        .rdata (rd_data)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign count = wr_ptr - rd_ptr;

    // push_ready depends only on state, so there is no pop_ready -> push_ready path.
    assign fq.push_ready = !full;
    // A push that coincides with a flush belongs to the wrong path.
    assign push_fire     = fq.push_valid && !full && !flush;

`ifdef FQ_BYPASS_EN
    // Empty queue: the incoming pair is shown directly; if decode takes it
    // this cycle it never occupies a slot.
    assign fq.pop_valid = !flush && (!empty || fq.push_valid);
    assign fq.pop_pc    = empty ? fq.push_pc    : rd_data[2*XLEN-1:XLEN];
    assign fq.pop_instr = empty ? fq.push_instr : rd_data[XLEN-1:0];
    assign pop_fire     = !flush && !empty && fq.pop_ready;
    assign store_push   = push_fire && !(empty && fq.pop_ready);
`else
    assign fq.pop_valid = !empty && !flush;
    assign fq.pop_pc    = rd_data[2*XLEN-1:XLEN];
    assign fq.pop_instr = rd_data[XLEN-1:0];
    assign pop_fire     = fq.pop_valid && fq.pop_ready;
    assign store_push   = push_fire;
`endif

    // Pointer update: flush empties the queue by catching rd up to wr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (store_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_fire)   rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue (DEPTH=4, XLEN=32).
// Each table row is one clock cycle: inputs plus the outputs expected before
// the edge. Reset-mid-stream and bypass behaviour are hand-written sequences.
module tb_if_fetch_queue;
    import rv32im_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef FQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    if_fetch_queue_if #(.XLEN(32)) fq ();

    if_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .fq    (fq),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        pv;
        logic [31:0] ppc;
        logic        pr;
        logic        e_prdy;
        logic        e_pval;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return 32'h1300_0000 | pc;
    endfunction

    function automatic void add(input logic fl, input logic pv, input logic [31:0] ppc,
                                input logic pr, input logic e_prdy, input logic e_pval,
                                input logic [31:0] e_pc, input int e_cnt);
        vec_t v;
        v.fl = fl; v.pv = pv; v.ppc = ppc; v.pr = pr;
        v.e_prdy = e_prdy; v.e_pval = e_pval; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic pv, input logic [31:0] ppc, input logic pr);
        flush         = fl;
        fq.push_valid = pv;
        fq.push_pc    = ppc;
        fq.push_instr = iw(ppc);
        fq.pop_ready  = pr;
    endtask

    task automatic check_outs(input string tag, input logic e_prdy, input logic e_pval,
                              input logic [31:0] e_pc, input int e_cnt);
        chk({tag, " push_ready"}, 32'(fq.push_ready), 32'(e_prdy));
        chk({tag, " pop_valid"},  32'(fq.pop_valid),  32'(e_pval));
        chk({tag, " count"},      32'(count),         32'(e_cnt));
        if (e_pval) begin
            chk({tag, " pop_pc"},    fq.pop_pc,    e_pc);
            chk({tag, " pop_instr"}, fq.pop_instr, iw(e_pc));
        end
    endtask

    initial begin
        // Reset, then three pushes with decode stalled.
        add(0, 1, 32'h0,  0, 1, BYP, 32'h0, 0);
        add(0, 1, 32'h4,  0, 1, 1,   32'h0, 1);
        add(0, 1, 32'h8,  0, 1, 1,   32'h0, 2);
        add(0, 0, 32'h0,  0, 1, 1,   32'h0, 3);
        // Fill, hold push_valid while full, pop one, refill.
        add(0, 1, 32'hC,  0, 1, 1,   32'h0, 3);
        add(0, 1, 32'h10, 0, 0, 1,   32'h0, 4);
        add(0, 1, 32'h10, 1, 0, 1,   32'h0, 4);
        add(0, 1, 32'h10, 0, 1, 1,   32'h4, 3);
        add(0, 0, 32'h0,  0, 0, 1,   32'h4, 4);
        // Drain, then pop_ready on an empty queue.
        add(0, 0, 32'h0,  1, 0, 1,   32'h4, 4);
        add(0, 0, 32'h0,  1, 1, 1,   32'h8, 3);
        add(0, 0, 32'h0,  1, 1, 1,   32'hC, 2);
        add(0, 0, 32'h0,  1, 1, 1,   32'h10, 1);
        add(0, 0, 32'h0,  1, 1, 0,   32'h0, 0);
        // Steady push+pop across the pointer wrap.
        add(0, 1, 32'h0,  0, 1, BYP, 32'h0, 0);
        for (int k = 1; k <= 10; k++)
            add(0, 1, 32'(4*k), 1, 1, 1, 32'(4*(k-1)), 1);
        add(0, 0, 32'h0,  0, 1, 1,   32'h28, 1);
        // Flush with three entries and a same-cycle push of 0x40.
        add(0, 1, 32'h2C, 0, 1, 1,   32'h28, 1);
        add(0, 1, 32'h30, 0, 1, 1,   32'h28, 2);
        add(1, 1, 32'h40, 1, 1, 0,   32'h0, 3);
        add(0, 0, 32'h0,  0, 1, 0,   32'h0, 0);
        add(0, 1, 32'h44, 0, 1, BYP, 32'h44, 0);
        add(0, 0, 32'h0,  0, 1, 1,   32'h44, 1);
        add(0, 0, 32'h0,  1, 1, 1,   32'h44, 1);
        add(0, 0, 32'h0,  0, 1, 0,   32'h0, 0);

        drive(0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b1, 1'b0, 32'h0, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].pv, vecs[i].ppc, vecs[i].pr);
            @(negedge clk);
            check_outs($sformatf("row%0d", i), vecs[i].e_prdy, vecs[i].e_pval,
                       vecs[i].e_pc, vecs[i].e_cnt);
            @(posedge clk); #1;
        end

        // Asynchronous reset with two entries held.
        drive(0, 1, 32'h50, 0);
        @(posedge clk); #1;
        drive(0, 1, 32'h54, 0);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 0);
        @(negedge clk);
        check_outs("pre_rst", 1'b1, 1'b1, 32'h50, 2);
        #2 rst = 1'b0;
        #1 check_outs("async_rst", 1'b1, 1'b0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Push into an empty queue with decode ready.
        drive(0, 1, 32'h100, 1);
        @(negedge clk);
        check_outs("byp_same", 1'b1, BYP, 32'h100, 0);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 0);
        @(negedge clk);
        check_outs("byp_next", 1'b1, !BYP, 32'h100, BYP ? 0 : 1);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 1);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 0);
        @(negedge clk);
        check_outs("byp_drain", 1'b1, 1'b0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
